program_loader: RTL

Boot-time instruction-memory writer: receives a length-prefixed byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words and writes them to consecutive instruction-memory addresses. It is the write-side counterpart of the processor's instruction fetch port. The instruction memory is addressed by a 12-bit word address and holds 32-bit words with the opcode in bits [31:26]. The loader fills that memory before the processor is released to fetch from address BASE_ADDR.

---
 rtl/program_loader.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/program_loader.sv
// Boot-time instruction-memory loader: length-prefixed byte stream in, big-endian 32-bit words written out.
// Optional feature macro LOADER_CHECKSUM_EN adds a trailing XOR checksum byte and the CHECK state.
module program_loader #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_data,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_loaded
);
    localparam int unsigned CNT_W     = 16;
    localparam int unsigned MAX_WORDS = (32'd1 << ADDR_WIDTH) - BASE_ADDR;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_DONE,
`ifdef LOADER_CHECKSUM_EN
        S_CHECK,
`endif
        S_ERROR
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count;
    logic [1:0]       byte_idx;
    logic [23:0]      shift;
    logic             start_acc;
    logic             word_end;
    logic             last_word;
    logic             len_bad;
    logic             busy_next;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]       csum;
`endif

    assign last_word = (32'(words_loaded) + 32'd1) == 32'(count);
    // Evaluated while the low length byte is on byte_in, before it is latched.
    assign len_bad   = ({count[CNT_W-1:8], byte_in} == 16'd0) ||
                       (32'({count[CNT_W-1:8], byte_in}) > MAX_WORDS);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        byte_ready = 1'b0;
        start_acc  = 1'b0;
        word_end   = 1'b0;
        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                // The trailing write cycle of the last word still counts as busy.
                if (start && !mem_we) begin
                    start_acc  = 1'b1;
                    state_next = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                byte_ready = 1'b1;
                if (byte_valid) state_next = S_LEN_LO;
            end
            S_LEN_LO: begin
                byte_ready = 1'b1;
                if (byte_valid) state_next = len_bad ? S_ERROR : S_DATA;
            end
            S_DATA: begin
                byte_ready = 1'b1;
                if (byte_valid && byte_idx == 2'd3) begin
                    word_end = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    if (last_word) state_next = S_CHECK;
`else
                    if (last_word) state_next = S_DONE;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                byte_ready = 1'b1;
                if (byte_valid) state_next = (byte_in == csum) ? S_DONE : S_ERROR;
            end
`endif
            default: state_next = S_IDLE;
        endcase
        busy_next = word_end || !(state_next inside {S_IDLE, S_DONE, S_ERROR});
    end

    // Datapath: length capture, word assembly, write port and status flags.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count        <= '0;
            byte_idx     <= '0;
            shift        <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_data     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum         <= '0;
`endif
        end else begin
            mem_we <= word_end;
            busy   <= busy_next;
            if (start_acc) begin
                done         <= 1'b0;
                error        <= 1'b0;
                words_loaded <= '0;
                byte_idx     <= '0;
`ifdef LOADER_CHECKSUM_EN
                csum         <= '0;
`endif
            end else begin
                if (state_next == S_DONE && state != S_DONE)   done  <= 1'b1;
                if (state_next == S_ERROR && state != S_ERROR) error <= 1'b1;
            end
            if (byte_ready && byte_valid) begin
                case (state)
                    S_LEN_HI: count[CNT_W-1:8] <= byte_in;
                    S_LEN_LO: count[7:0]       <= byte_in;
                    S_DATA: begin
                        shift    <= {shift[15:0], byte_in};
                        byte_idx <= byte_idx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        csum     <= csum ^ byte_in;
`endif
                    end
                    default: ;
                endcase
            end
            if (word_end) begin
                mem_addr     <= ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(words_loaded);
                mem_data     <= {shift, byte_in};
                words_loaded <= words_loaded + (ADDR_WIDTH + 1)'(1);
            end
        end
    end
endmodule
